// File: rtl/tile_map_scheduler_if.sv
// Scheduler-side bundle: frame trigger, map RAM read port,
// tile drawer request/handshake and status flags.
interface tile_map_scheduler_if;
  logic        start;
  logic [4:0]  map_data;
  logic        drawer_active;
  logic [8:0]  map_addr;
  logic [11:0] tile_address;
  logic [7:0]  x_pos;
  logic [7:0]  y_pos;
  logic        draw;
  logic        busy;
  logic        frame_done;
  logic        timeout_err;

  modport master (
    input  start,
    input  map_data,
    input  drawer_active,
    output map_addr,
    output tile_address,
    output x_pos,
    output y_pos,
    output draw,
    output busy,
    output frame_done,
    output timeout_err
  );

  modport slave (
    output start,
    output map_data,
    output drawer_active,
    input  map_addr,
    input  tile_address,
    input  x_pos,
    input  y_pos,
    input  draw,
    input  busy,
    input  frame_done,
    input  timeout_err
  );
endinterface

// File: rtl/tile_map_scheduler.sv
// Frame sequencer: walks the tile map, turns each index into a
// tile-ROM address and screen position, one drawer request per tile.
module tile_map_scheduler #(
  parameter int COLS        = 20,
  parameter int ROWS        = 15,
  parameter int TILE_BYTES  = 192,
  parameter int NUM_TILES   = 21,
  parameter int ACK_TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  resetn,
  tile_map_scheduler_if.master bus
);

  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [8:0] LAST_IDX = 9'(COLS * ROWS - 1);
  localparam logic [4:0] TILES_N  = 5'(NUM_TILES);
  localparam logic [3:0] ACK_MAX  = 4'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_ADV,
    S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  col, col_nx;
  logic [3:0]  row, row_nx;
  logic [8:0]  idx, idx_nx;
  logic [3:0]  ack, ack_nx;
  logic [11:0] tile_q, tile_nx;
  logic [7:0]  x_q, x_nx;
  logic [7:0]  y_q, y_nx;
  logic        terr, terr_nx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      col    <= '0;
      row    <= '0;
      idx    <= '0;
      ack    <= '0;
      tile_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      terr   <= 1'b0;
    end else begin
      state  <= state_nx;
      col    <= col_nx;
      row    <= row_nx;
      idx    <= idx_nx;
      ack    <= ack_nx;
      tile_q <= tile_nx;
      x_q    <= x_nx;
      y_q    <= y_nx;
      terr   <= terr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    idx_nx   = idx;
    ack_nx   = ack;
    tile_nx  = tile_q;
    x_nx     = x_q;
    y_nx     = y_q;
    terr_nx  = terr;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          col_nx   = '0;
          row_nx   = '0;
          idx_nx   = '0;
          terr_nx  = 1'b0;
          state_nx = S_READ;
        end
      end
      S_READ: state_nx = S_LATCH;
      S_LATCH: begin
        // Out-of-range indices are holes in the map: no draw.
        if (bus.map_data >= TILES_N) begin
          state_nx = S_ADV;
        end else begin
          tile_nx  = 12'(32'(bus.map_data) * TILE_BYTES);
          x_nx     = {col, 3'b000};
          y_nx     = {1'b0, row, 3'b000};
          ack_nx   = '0;
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ack_nx = ack + 4'd1;
        if (bus.drawer_active) begin
          state_nx = S_WAIT;
        end else if (ack_nx == ACK_MAX) begin
          terr_nx  = 1'b1;
          state_nx = S_ADV;
        end
      end
      S_WAIT: begin
        if (!bus.drawer_active) state_nx = S_ADV;
      end
      S_ADV: begin
        if (idx == LAST_IDX) begin
          state_nx = S_DONE;
        end else begin
          idx_nx = idx + 9'd1;
          if (col == LAST_COL) begin
            col_nx = '0;
            row_nx = row + 4'd1;
          end else begin
            col_nx = col + 5'd1;
          end
          state_nx = S_READ;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.map_addr     = idx;
  assign bus.tile_address = tile_q;
  assign bus.x_pos        = x_q;
  assign bus.y_pos        = y_q;
  assign bus.draw         = (state == S_ISSUE);
  assign bus.busy         = (state != S_IDLE);
  assign bus.frame_done   = (state == S_DONE);
  assign bus.timeout_err  = terr;

endmodule

// File: tb/tb_tile_map_scheduler.sv
// Bench for tile_map_scheduler: map RAM and drawer models plus a
// tile-level reference of draws and frame length.
module tb_tile_map_scheduler;
  logic clk;
  logic resetn;

  tile_map_scheduler_if bus();

  tile_map_scheduler dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [4:0] mem [300];

  always @(posedge clk) bus.map_data <= mem[bus.map_addr];

  // Drawer: active drv_dly cycles after draw, for drv_len cycles.
  int drv_dly, drv_len, hold, dly;
  bit drv_never, armed;

  always @(posedge clk) begin
    if (!resetn) begin
      bus.drawer_active <= 1'b0;
      armed <= 1'b0;
      hold  <= 0;
      dly   <= 0;
    end else if (bus.drawer_active) begin
      if (hold <= 1) bus.drawer_active <= 1'b0;
      hold <= hold - 1;
    end else if (armed) begin
      if (dly <= 1) begin
        bus.drawer_active <= 1'b1;
        hold  <= drv_len;
        armed <= 1'b0;
      end
      dly <= dly - 1;
    end else if (bus.draw && !drv_never) begin
      if (drv_dly <= 1) begin
        bus.drawer_active <= 1'b1;
        hold <= drv_len;
      end else begin
        armed <= 1'b1;
        dly   <= drv_dly - 1;
      end
    end
  end

  typedef logic [36:0] rec_t;
  rec_t dq[$];
  rec_t eq[$];

  int checks, errors;
  int ncnt, t0;
  int draw_cyc, overlap, unstable;
  int fd_n, fd_at, fd_last, te_first;
  int busy_p1, busy_p2;
  bit pdraw, pact;
  logic [27:0] plat;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [40:0] outs();
    return {bus.map_addr, bus.tile_address, bus.x_pos, bus.y_pos,
            bus.draw, bus.busy, bus.frame_done, bus.timeout_err};
  endfunction

  task automatic tick();
    logic [27:0] lat;
    @(negedge clk);
    ncnt++;
    lat = {bus.tile_address, bus.x_pos, bus.y_pos};
    if (bus.draw && !pdraw) dq.push_back({bus.map_addr, lat});
    if (bus.draw) draw_cyc++;
    if (bus.draw && bus.frame_done) overlap++;
    if ((bus.draw || bus.drawer_active) && (pdraw || pact) && lat !== plat)
      unstable++;
    if (bus.timeout_err && te_first < 0) te_first = ncnt - t0;
    if (bus.frame_done) begin
      fd_n++;
      if (fd_n == 1) fd_at = ncnt - t0;
      fd_last = ncnt - t0;
    end
    if (fd_n > 0 && ncnt - t0 == fd_at + 1) busy_p1 = int'(bus.busy);
    if (fd_n > 0 && ncnt - t0 == fd_at + 2) busy_p2 = int'(bus.busy);
    pdraw = bus.draw;
    pact  = bus.drawer_active;
    plat  = lat;
  endtask

  task automatic clear_mon();
    dq.delete();
    draw_cyc = 0;
    overlap  = 0;
    unstable = 0;
    fd_n     = 0;
    fd_at    = -1;
    fd_last  = -1;
    te_first = -1;
    busy_p1  = -1;
    busy_p2  = -1;
  endtask

  task automatic run_frame(input int budget, input bit hold_start,
                           input int repulse);
    clear_mon();
    bus.start = 1'b1;
    t0 = ncnt;
    tick();
    if (!hold_start) bus.start = 1'b0;
    while (fd_n == 0 && ncnt - t0 < budget) begin
      tick();
      if (repulse > 0) bus.start = (ncnt - t0 == repulse);
    end
    bus.start = hold_start;
    if (hold_start) begin
      repeat (2) tick();
      bus.start = 1'b0;
      while (fd_n < 2 && ncnt - t0 < 2 * budget) tick();
    end
    repeat (4) tick();
  endtask

  // Reference: per tile 3 cycles if skipped, 18 if timed out,
  // else READ+LATCH+ISSUE(dly+1)+WAIT(len)+ADVANCE.
  task automatic build_exp(output int cyc, output int dcyc, output bit te);
    eq.delete();
    cyc  = 0;
    dcyc = 0;
    te   = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (int'(mem[t]) < 21) begin
        eq.push_back({9'(t), 12'(int'(mem[t]) * 192),
                      8'((t % 20) * 8), 8'((t / 20) * 8)});
        if (drv_never) begin
          cyc  += 18;
          dcyc += 15;
          te    = 1'b1;
        end else begin
          cyc  += 4 + drv_dly + drv_len;
          dcyc += drv_dly + 1;
        end
      end else begin
        cyc += 3;
      end
    end
    cyc += 1;
  endtask

  task automatic check_frame(input string tag);
    int cyc, dcyc, n;
    bit te;
    build_exp(cyc, dcyc, te);
    chk({tag, ".done_cycle"}, 64'(fd_at), 64'(cyc));
    chk({tag, ".done_count"}, 64'(fd_n), 64'(1));
    chk({tag, ".draw_count"}, 64'(dq.size()), 64'(eq.size()));
    n = (dq.size() < eq.size()) ? dq.size() : eq.size();
    for (int i = 0; i < n; i++)
      chk({tag, ".draw_rec"}, 64'(dq[i]), 64'(eq[i]));
    chk({tag, ".draw_cycles"}, 64'(draw_cyc), 64'(dcyc));
    chk({tag, ".draw_vs_done"}, 64'(overlap), 64'(0));
    chk({tag, ".stable"}, 64'(unstable), 64'(0));
    chk({tag, ".timeout_err"}, 64'(bus.timeout_err), 64'(te));
    chk({tag, ".busy_after"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic fill(input logic [4:0] v);
    for (int t = 0; t < 300; t++) mem[t] = v;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ncnt = 0;
    t0 = 0;
    pdraw = 1'b0;
    pact = 1'b0;
    plat = '0;
    bus.start = 1'b0;
    drv_never = 1'b0;
    drv_dly = 1;
    drv_len = 4;
    fill(5'd31);
    clear_mon();
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (3) tick();
    chk("reset.outs", 64'(outs()), 64'(0));
    resetn = 1'b1;
    clear_mon();
    repeat (5) tick();
    chk("idle.outs", 64'(outs()), 64'(0));
    chk("idle.draws", 64'(dq.size()), 64'(0));

    // All holes: no draws, done in cycle 901.
    run_frame(2000, 1'b0, 0);
    check_frame("invalid");
    chk("invalid.busy_902", 64'(busy_p1), 64'(0));

    // Single tile at row 2, col 3, long drawer busy time.
    mem[43] = 5'd5;
    drv_len = 704;
    run_frame(3000, 1'b0, 0);
    check_frame("one_tile");

    // Last tile, highest valid index.
    fill(5'd31);
    mem[299] = 5'd20;
    drv_len = 3;
    run_frame(2000, 1'b0, 0);
    check_frame("last_tile");

    // Drawer never answers: every tile times out.
    fill(5'd0);
    drv_never = 1'b1;
    run_frame(6000, 1'b0, 0);
    check_frame("timeout");
    chk("timeout.first_set", 64'(te_first), 64'(18));

    // Random maps and drawer timing; a new start clears the error.
    drv_never = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int t = 0; t < 300; t++) mem[t] = 5'($urandom_range(0, 31));
      drv_dly = int'($urandom_range(1, 14));
      drv_len = int'($urandom_range(1, 6));
      run_frame(8000, 1'b0, (f == 1) ? int'($urandom_range(10, 400)) : 0);
      check_frame("random");
      chk("random.err_cleared", 64'(te_first), 64'(-1));
    end

    // Start held high: back-to-back frames.
    fill(5'd31);
    run_frame(2000, 1'b1, 0);
    chk("hold.first_done", 64'(fd_at), 64'(901));
    chk("hold.idle_gap", 64'(busy_p1), 64'(0));
    chk("hold.restart", 64'(busy_p2), 64'(1));
    chk("hold.second_done", 64'(fd_last), 64'(901 + 902));
    chk("hold.done_count", 64'(fd_n), 64'(2));

    // Reset while the drawer is busy on tile 0.
    mem[0] = 5'd3;
    drv_dly = 1;
    drv_len = 50;
    clear_mon();
    bus.start = 1'b1;
    t0 = ncnt;
    tick();
    bus.start = 1'b0;
    while (!(bus.drawer_active && !bus.draw && bus.busy) && ncnt - t0 < 40)
      tick();
    chk("rst.reached_wait", 64'(ncnt - t0 < 40), 64'(1));
    #2 resetn = 1'b0;
    #1;
    chk("rst.outs_async", 64'(outs()), 64'(0));
    tick();
    resetn = 1'b1;
    clear_mon();
    repeat (20) tick();
    chk("rst.no_resume", 64'(outs()), 64'(0));
    chk("rst.no_draw", 64'(dq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
